hex_display_ctrl: RTL and testbench

Parametrised multi-digit hexadecimal seven-segment display controller for the DE0-CV HEX displays and external multiplexed modules. It captures an N-nibble value plus display attributes on a load strobe and drives registered active-low segment patterns. Supported features are per-digit blanking, per-digit blink, leading-zero suppression, and a time-multiplexed scan output. It sits between the UART/debug datapath and the board display pins.

---
 rtl/hex_disp_pkg.sv | 16 +
 rtl/seg7_lut.sv | 14 +
 rtl/hex_display_ctrl.sv | 149 ++++++++++++++
 tb/tb_hex_display_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and segment tables for the hex display controller.
// Segment patterns are gfedcba, active-low (0 = segment lit).
package hex_disp_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t SEG_CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_lut.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_lut
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Table lookup covers all 16 nibble codes.
    always_comb begin
        seg = SEG_CODES[nibble];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: shadow capture, blanking, blink,
// leading-zero suppression, and a registered time-multiplexed scan output.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [6:0]              seg_scan,
    output logic [NUM_DIGITS-1:0]   dig_scan_n,
    output logic                    updated
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value_r;
    logic [NUM_DIGITS-1:0]   blank_r;
    logic [NUM_DIGITS-1:0]   blink_r;
    logic                    lz_r;
    logic                    load_d_r;

    logic [BLINK_W-1:0]      blink_cnt_r;
    logic                    blink_on_r;
    logic [SCAN_W-1:0]       scan_cnt_r;
    logic [IDX_W-1:0]        scan_idx_r;

    seg7_t                   decode_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   suppress_s;
    logic                    zero_run_s;
    logic [7*NUM_DIGITS-1:0] hex_next_s;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
        seg7_lut u_lut (
            .nibble (value_r[4*g +: 4]),
            .seg    (decode_s[g])
        );
    end

    // Zero nibbles from the top digit down are suppressed until the first nonzero one; digit 0 always shows.
    always_comb begin
        zero_run_s = 1'b1;
        suppress_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (lz_r && zero_run_s && (i != 0) && (value_r[4*i +: 4] == 4'h0)) begin
                suppress_s[i] = 1'b1;
            end else begin
                suppress_s[i] = 1'b0;
                zero_run_s    = 1'b0;
            end
        end
    end

    // Per-digit priority: forced blank, then zero suppression, then blink-off, then decode.
    always_comb begin
        hex_next_s = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blank_r[i]) begin
                hex_next_s[7*i +: 7] = SEG_BLANK;
            end else if (suppress_s[i]) begin
                hex_next_s[7*i +: 7] = SEG_BLANK;
            end else if (!blink_on_r && blink_r[i]) begin
                hex_next_s[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next_s[7*i +: 7] = decode_s[i];
            end
        end
    end

    // Shadow capture of display content on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r  <= '0;
            blank_r  <= '0;
            blink_r  <= '0;
            lz_r     <= 1'b0;
            load_d_r <= 1'b0;
        end else begin
            load_d_r <= load;
            if (load) begin
                value_r <= value;
                blank_r <= blank_mask;
                blink_r <= blink_mask;
                lz_r    <= lz_en;
            end else begin
                value_r <= value_r;
                blank_r <= blank_r;
                blink_r <= blink_r;
                lz_r    <= lz_r;
            end
        end
    end

    // Free-running blink timebase; load never disturbs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Scan timebase: dwell counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            scan_idx_r <= '0;
        end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_r <= '0;
            if (scan_idx_r == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx_r <= '0;
            end else begin
                scan_idx_r <= scan_idx_r + IDX_W'(1);
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Registered outputs; seg_scan shares hex_next_s so it always matches the selected hex_out slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out    <= '1;
            seg_scan   <= SEG_BLANK;
            dig_scan_n <= '1;
            updated    <= 1'b0;
        end else begin
            hex_out    <= hex_next_s;
            seg_scan   <= hex_next_s[7*scan_idx_r +: 7];
            dig_scan_n <= ~(NUM_DIGITS'(1) << scan_idx_r);
            updated    <= load_d_r;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (4 digits, fast blink/scan).
module tb_hex_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        lz_en;
    logic [27:0] hex_out;
    logic [6:0]  seg_scan;
    logic [3:0]  dig_scan_n;
    logic        updated;

    int checks = 0;
    int errors = 0;

    logic [6:0] blink_s [40];
    logic [3:0] scan_s  [24];
    int         last_t;
    int         ntr;
    int         k;
    int         p0;
    int         idx;
    logic [3:0] exp_d;

    hex_display_ctrl #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (8),
        .SCAN_DIV   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .hex_out    (hex_out),
        .seg_scan   (seg_scan),
        .dig_scan_n (dig_scan_n),
        .updated    (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] km, input logic lz);
        value      = v;
        blank_mask = bm;
        blink_mask = km;
        lz_en      = lz;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; value = 16'h0000;
        blank_mask = 4'h0; blink_mask = 4'h0; lz_en = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hex", 32'(hex_out), 32'h0FFFFFFF);
        check("rst_seg", 32'(seg_scan), 32'h7F);
        check("rst_dig", 32'(dig_scan_n), 32'hF);
        check("rst_upd", 32'(updated), 32'h0);
        rst_n = 1'b1;
        step();
        check("first_dig", 32'(dig_scan_n), 32'hE);
        check("first_hex", 32'(hex_out), 32'({4{7'b1000000}}));
        check("first_seg", 32'(seg_scan), 32'h40);

        // Basic load with two-edge latency and single updated pulse
        do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
        check("ld_hex_old", 32'(hex_out), 32'({4{7'b1000000}}));
        check("ld_upd_early", 32'(updated), 32'h0);
        step();
        check("ld_hex_new", 32'(hex_out), 32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
        check("ld_upd", 32'(updated), 32'h1);
        step();
        check("ld_upd_off", 32'(updated), 32'h0);
        check("ld_hex_hold", 32'(hex_out), 32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));

        // Scan sequence and seg_scan tracking hex_out slice
        for (int i = 0; i < 24; i++) begin
            step();
            scan_s[i] = dig_scan_n;
            idx = 0;
            for (int j = 0; j < 4; j++) begin
                if (dig_scan_n[j] == 1'b0) idx = j;
            end
            check("scan_seg", 32'(seg_scan), 32'(hex_out[7*idx +: 7]));
        end
        k = 0;
        for (int i = 4; i >= 1; i--) begin
            if (scan_s[i] != scan_s[i-1]) k = i;
        end
        check("scan_change", 32'(k != 0), 32'h1);
        p0 = 0;
        for (int j = 0; j < 4; j++) begin
            if (scan_s[k][j] == 1'b0) p0 = j;
        end
        for (int m = 0; m < 16; m++) begin
            exp_d = ~(4'b0001 << ((p0 + m / 4) % 4));
            check("scan_seq", 32'(scan_s[k+m]), 32'(exp_d));
        end

        // Leading-zero suppression with back-to-back loads
        value = 16'h0050; blank_mask = 4'h0; blink_mask = 4'h0; lz_en = 1'b1; load = 1'b1;
        step();
        value = 16'h0000;
        step();
        load = 1'b0;
        check("lz_0050", 32'(hex_out), 32'({7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}));
        check("lz_upd1", 32'(updated), 32'h1);
        step();
        check("lz_0000", 32'(hex_out), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));
        check("lz_upd2", 32'(updated), 32'h1);
        step();
        check("lz_upd_off", 32'(updated), 32'h0);

        // Blink on digit 0 with a mid-period reload
        do_load(16'h0003, 4'h0, 4'h1, 1'b0);
        step();
        for (int i = 0; i < 40; i++) begin
            value = 16'h0003; blink_mask = 4'h1;
            load = (i == 13);
            step();
            blink_s[i] = hex_out[6:0];
            check("blink_other", 32'(hex_out[27:7]), 32'({3{7'b1000000}}));
            check("blink_level", 32'((blink_s[i] == 7'b0110000) || (blink_s[i] == 7'b1111111)), 32'h1);
        end
        load = 1'b0;
        last_t = -1;
        ntr = 0;
        for (int i = 1; i < 40; i++) begin
            if (blink_s[i] != blink_s[i-1]) begin
                if (last_t >= 0) check("blink_period", 32'(i - last_t), 32'd8);
                last_t = i;
                ntr++;
            end
        end
        check("blink_toggles", 32'(ntr >= 4), 32'h1);

        // Blank mask dominates blink and lz on nonzero digit 2
        do_load(16'h0300, 4'b0100, 4'b0100, 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            check("blank_prio", 32'(hex_out), 32'({7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000}));
        end

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hex", 32'(hex_out), 32'h0FFFFFFF);
        check("arst_seg", 32'(seg_scan), 32'h7F);
        check("arst_dig", 32'(dig_scan_n), 32'hF);
        check("arst_upd", 32'(updated), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
